two_digit_count_ctrl: RTL and testbench

- Sequencing controller for the two-digit counter display path.
- Generates the time base, runs a two-digit BCD up/down count (00..99), and handles run/stop, clear and load from board keys and switches.
- Drives two 4-bit BCD digits, each feeding one instance of the existing BCD-to-7-segment decoder.
- Decoder inputs are therefore always valid BCD values 0..9.

---
 rtl/two_digit_count_ctrl.sv | 149 ++++++++++++++
 tb/tb_two_digit_count_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/two_digit_count_ctrl.sv
// rtl/two_digit_count_ctrl.sv - two-digit BCD up/down counter controller with run/stop, clear and load
module two_digit_count_ctrl #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_run,
    input  logic       btn_clr,
    input  logic       dir_down,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       running,
    output logic       wrap
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] pre_q, pre_d;
    logic [3:0]       ones_q, ones_d;
    logic [3:0]       tens_q, tens_d;
    logic             running_q, running_d;
    logic             wrap_q, wrap_d;
    logic             btn_run_q, btn_run_d;
    logic             btn_clr_q, btn_clr_d;
    logic             armed_q, armed_d;

    logic rise_run;
    logic rise_clr;
    logic tick;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    // The edge registers restart at 0 out of reset; armed_q masks the first
    // cycle so a key held through reset release is not seen as a fresh press.
    always_comb begin
        btn_run_d = btn_run;
        btn_clr_d = btn_clr;
        armed_d   = 1'b1;
        rise_run  = btn_run & ~btn_run_q & armed_q;
        rise_clr  = btn_clr & ~btn_clr_q & armed_q;
    end

    assign tick = (state_q == ST_RUN) && (pre_q == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_STOP;
            pre_q     <= '0;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
            btn_run_q <= 1'b0;
            btn_clr_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            running_q <= running_d;
            wrap_q    <= wrap_d;
            btn_run_q <= btn_run_d;
            btn_clr_q <= btn_clr_d;
            armed_q   <= armed_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: if (rise_run) state_d = ST_RUN;
            ST_RUN:  if (rise_run) state_d = ST_STOP;
            default: state_d = ST_STOP;
        endcase
    end

    always_comb begin
        running_d = (state_d == ST_RUN);
    end

    // Prescaler only advances while staying in RUN; any stop or clear discards it.
    always_comb begin
        pre_d = pre_q;
        if (state_d != ST_RUN || state_q != ST_RUN || rise_clr) begin
            pre_d = '0;
        end else if (tick) begin
            pre_d = '0;
        end else begin
            pre_d = pre_q + CNT_W'(1);
        end
    end

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        wrap_d = 1'b0;
        if (rise_clr) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (tick) begin
            if (!dir_down) begin
                if (ones_q >= 4'd9) begin
                    ones_d = 4'd0;
                    if (tens_q >= 4'd9) begin
                        tens_d = 4'd0;
                        wrap_d = 1'b1;
                    end else begin
                        tens_d = tens_q + 4'd1;
                    end
                end else begin
                    ones_d = ones_q + 4'd1;
                end
            end else begin
                if (ones_q == 4'd0) begin
                    ones_d = 4'd9;
                    if (tens_q == 4'd0) begin
                        tens_d = 4'd9;
                        wrap_d = 1'b1;
                    end else begin
                        tens_d = tens_q - 4'd1;
                    end
                end else begin
                    ones_d = ones_q - 4'd1;
                end
            end
        end else if (state_q == ST_STOP && load) begin
            ones_d = bcd_clamp(load_val[3:0]);
            tens_d = bcd_clamp(load_val[7:4]);
        end
    end

    assign ones    = ones_q;
    assign tens    = tens_q;
    assign running = running_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_two_digit_count_ctrl.sv
// tb/tb_two_digit_count_ctrl.sv - directed self-checking bench for two_digit_count_ctrl
module tb_two_digit_count_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_run;
    logic       btn_clr;
    logic       dir_down;
    logic       load;
    logic [7:0] load_val;
    logic [3:0] ones;
    logic [3:0] tens;
    logic       running;
    logic       wrap;

    int compared;
    int mismatched;

    logic [9:0] obs;
    logic [9:0] exp;
    assign obs = {tens, ones, running, wrap};

    two_digit_count_ctrl #(
        .TICK_DIV(4),
        .CNT_W   (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_run (btn_run),
        .btn_clr (btn_clr),
        .dir_down(dir_down),
        .load    (load),
        .load_val(load_val),
        .ones    (ones),
        .tens    (tens),
        .running (running),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick_n(2);
        exp = {4'd0, 4'd0, 1'b0, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL reset_values: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        reset = 1'b0;
        tick_n(1);
    endtask

    task automatic test_first_step;
        btn_run = 1'b1;
        tick_n(1);
        btn_run = 1'b0;
        exp = {4'd0, 4'd0, 1'b1, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL run_edge: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        tick_n(3);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL before_first_step: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        tick_n(1);
        exp = {4'd0, 4'd1, 1'b1, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL first_step: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        tick_n(4);
        exp = {4'd0, 4'd2, 1'b1, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL second_step: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        btn_run = 1'b1;
        tick_n(1);
        btn_run = 1'b0;
        exp = {4'd0, 4'd2, 1'b0, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL stop_edge: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        tick_n(1);
    endtask

    task automatic test_wrap_up;
        dir_down = 1'b0;
        load     = 1'b1;
        load_val = 8'h98;
        tick_n(1);
        load = 1'b0;
        exp = {4'd9, 4'd8, 1'b0, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL load_98: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        btn_run = 1'b1;
        tick_n(1);
        btn_run = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tick_n(1);
            compared++;
            if (ones > 4'd9 || tens > 4'd9) begin
                mismatched++;
                $display("FAIL bcd_range_c%0d: got tens=%0d ones=%0d want both <= 9", c, tens, ones);
            end
            if (c == 3 || c == 4 || c == 8 || c == 9) begin
                case (c)
                    3:       exp = {4'd9, 4'd8, 1'b1, 1'b0};
                    4:       exp = {4'd9, 4'd9, 1'b1, 1'b0};
                    8:       exp = {4'd0, 4'd0, 1'b1, 1'b1};
                    default: exp = {4'd0, 4'd0, 1'b1, 1'b0};
                endcase
                compared++;
                if (obs !== exp) begin
                    mismatched++;
                    $display("FAIL wrap_up_c%0d: got %b want %b (tens_ones_run_wrap)", c, obs, exp);
                end
            end
        end
        btn_run = 1'b1;
        tick_n(1);
        btn_run = 1'b0;
        tick_n(1);
    endtask

    task automatic test_down;
        dir_down = 1'b1;
        load     = 1'b1;
        load_val = 8'h00;
        tick_n(1);
        load    = 1'b0;
        btn_run = 1'b1;
        tick_n(1);
        btn_run = 1'b0;
        tick_n(4);
        exp = {4'd9, 4'd9, 1'b1, 1'b1};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL down_wrap: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        tick_n(1);
        exp = {4'd9, 4'd9, 1'b1, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL down_wrap_clear: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        tick_n(3);
        exp = {4'd9, 4'd8, 1'b1, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL down_98: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        btn_run = 1'b1;
        tick_n(1);
        btn_run  = 1'b0;
        load     = 1'b1;
        load_val = 8'h10;
        tick_n(1);
        load    = 1'b0;
        btn_run = 1'b1;
        tick_n(1);
        btn_run = 1'b0;
        tick_n(4);
        exp = {4'd0, 4'd9, 1'b1, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL borrow_10_09: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        btn_run = 1'b1;
        tick_n(1);
        btn_run  = 1'b0;
        dir_down = 1'b0;
        tick_n(1);
    endtask

    task automatic test_hold_run;
        load     = 1'b1;
        load_val = 8'h00;
        tick_n(1);
        load    = 1'b0;
        btn_run = 1'b1;
        tick_n(20);
        exp = {4'd0, 4'd4, 1'b1, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL hold_single_toggle: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        btn_run = 1'b0;
        tick_n(1);
        btn_run = 1'b1;
        tick_n(1);
        btn_run = 1'b0;
        tick_n(10);
        exp = {4'd0, 4'd5, 1'b0, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL stop_freeze: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        btn_run = 1'b1;
        tick_n(1);
        btn_run = 1'b0;
        tick_n(4);
        tick_n(1);
        btn_run = 1'b1;
        tick_n(1);
        btn_run = 1'b0;
        exp = {4'd0, 4'd6, 1'b0, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL stop_partial: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        tick_n(1);
        btn_run = 1'b1;
        tick_n(1);
        btn_run = 1'b0;
        tick_n(3);
        exp = {4'd0, 4'd6, 1'b1, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL restart_no_early_step: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        tick_n(1);
        exp = {4'd0, 4'd7, 1'b1, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL restart_step: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        btn_run = 1'b1;
        tick_n(1);
        btn_run = 1'b0;
        tick_n(1);
    endtask

    task automatic test_clear_load;
        load     = 1'b1;
        load_val = 8'h99;
        tick_n(1);
        load    = 1'b0;
        btn_run = 1'b1;
        tick_n(1);
        btn_run = 1'b0;
        tick_n(3);
        btn_clr = 1'b1;
        tick_n(1);
        btn_clr = 1'b0;
        exp = {4'd0, 4'd0, 1'b1, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL clear_on_tick: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        tick_n(4);
        exp = {4'd0, 4'd1, 1'b1, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL step_after_clear: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        load     = 1'b1;
        load_val = 8'h55;
        tick_n(2);
        load = 1'b0;
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL load_in_run: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        btn_run = 1'b1;
        tick_n(1);
        btn_run  = 1'b0;
        load     = 1'b1;
        load_val = 8'hAF;
        tick_n(1);
        exp = {4'd9, 4'd9, 1'b0, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL load_clamp: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        load_val = 8'h34;
        btn_clr  = 1'b1;
        tick_n(1);
        exp = {4'd0, 4'd0, 1'b0, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL clear_over_load: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        tick_n(1);
        exp = {4'd3, 4'd4, 1'b0, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL load_clr_held: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        load    = 1'b0;
        btn_clr = 1'b0;
        tick_n(1);
        btn_run = 1'b1;
        btn_clr = 1'b1;
        tick_n(1);
        btn_run = 1'b0;
        btn_clr = 1'b0;
        exp = {4'd0, 4'd0, 1'b1, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL run_and_clear: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        tick_n(4);
        exp = {4'd0, 4'd1, 1'b1, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL run_and_clear_step: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        btn_run = 1'b1;
        tick_n(1);
        btn_run = 1'b0;
        tick_n(1);
    endtask

    task automatic test_reset_mid;
        load     = 1'b1;
        load_val = 8'h57;
        tick_n(1);
        load    = 1'b0;
        btn_run = 1'b1;
        tick_n(1);
        exp = {4'd5, 4'd7, 1'b1, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL run_at_57: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        reset = 1'b1;
        tick_n(1);
        exp = {4'd0, 4'd0, 1'b0, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL reset_mid_run: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        reset = 1'b0;
        tick_n(3);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL held_through_reset: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        btn_run = 1'b0;
        tick_n(1);
        btn_run = 1'b1;
        tick_n(1);
        btn_run = 1'b0;
        exp = {4'd0, 4'd0, 1'b1, 1'b0};
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL run_after_reset: got %b want %b (tens_ones_run_wrap)", obs, exp);
        end
        tick_n(1);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        btn_run    = 1'b0;
        btn_clr    = 1'b0;
        dir_down   = 1'b0;
        load       = 1'b0;
        load_val   = 8'h00;
        test_reset();
        test_first_step();
        test_wrap_up();
        test_down();
        test_hold_run();
        test_clear_load();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
